// File: rtl/iomem_pkg.sv
// rtl/iomem_pkg.sv - shared types and constants for the iomem router family
package iomem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } iomem_state_t;

    localparam int          IOMEM_WIN_BITS  = 16;
    localparam logic [31:0] IOMEM_ERR_DATA  = 32'hDEAD_BEEF;
    localparam logic [31:0] IOMEM_GPIO_BASE = 32'h0300_0000;

endpackage

// File: rtl/iomem_addr_decode.sv
// rtl/iomem_addr_decode.sv - maps an iomem address onto one of NSLAVE 64 KiB windows
module iomem_addr_decode
    import iomem_pkg::*;
#(
    parameter int          NSLAVE = 4,
    parameter logic [31:0] BASE   = IOMEM_GPIO_BASE
) (
    input  logic [31:0] addr,
    output logic        hit,
    output logic [3:0]  sel
);

    logic [15:0] win;
    logic        unused_low;

    // Modular subtraction: addresses below BASE wrap to a large index and miss.
    assign win        = addr[31:IOMEM_WIN_BITS] - BASE[31:IOMEM_WIN_BITS];
    assign hit        = (win < 16'(NSLAVE));
    assign sel        = win[3:0];
    assign unused_low = ^addr[IOMEM_WIN_BITS-1:0];

endmodule

// File: rtl/iomem_router.sv
// rtl/iomem_router.sv - single-master iomem router with timeout and sticky error capture
module iomem_router
    import iomem_pkg::*;
#(
    parameter int          NSLAVE   = 4,
    parameter logic [31:0] BASE     = IOMEM_GPIO_BASE,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = IOMEM_ERR_DATA
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 m_valid,
    output logic                 m_ready,
    input  logic [3:0]           m_wstrb,
    input  logic [31:0]          m_addr,
    input  logic [31:0]          m_wdata,
    output logic [31:0]          m_rdata,
    output logic [NSLAVE-1:0]    s_valid,
    input  logic [NSLAVE-1:0]    s_ready,
    output logic [3:0]           s_wstrb,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    input  logic [32*NSLAVE-1:0] s_rdata,
    output logic                 err_irq,
    output logic [31:0]          err_addr,
    input  logic                 err_clear
);

    localparam int CW = $clog2(TIMEOUT + 1);

    iomem_state_t  state, state_next;
    logic [CW-1:0] cnt;
    logic [3:0]    sel;
    logic          dec_hit;
    logic [3:0]    dec_sel;
    logic          rdy_sel;
    logic [31:0]   rdata_sel;
    logic          timed_out;
    logic          accept;
    logic          err_raise;
    logic [31:0]   err_at;

    iomem_addr_decode #(.NSLAVE(NSLAVE), .BASE(BASE)) u_decode (
        .addr (m_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    // Only the selected slave's ready/data are observed; others are ignored.
    always_comb begin
        rdy_sel   = 1'b0;
        rdata_sel = 32'd0;
        for (int k = 0; k < NSLAVE; k++) begin
            if (sel == k[3:0]) begin
                rdy_sel   = s_ready[k];
                rdata_sel = s_rdata[32*k +: 32];
            end
        end
    end

    assign timed_out = (cnt == CW'(TIMEOUT - 1));
    assign accept    = m_valid && !m_ready;

    always_comb begin
        state_next = state;
        err_raise  = 1'b0;
        err_at     = m_addr;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_hit) begin
                        state_next = ST_ACCESS;
                    end else begin
                        state_next = ST_RESP;
                        err_raise  = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (rdy_sel) begin
                    state_next = ST_RESP;
                end else if (timed_out) begin
                    state_next = ST_RESP;
                    err_raise  = 1'b1;
                    err_at     = s_addr;
                end
            end
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_ready  <= 1'b0;
            m_rdata  <= 32'd0;
            s_valid  <= '0;
            s_wstrb  <= 4'd0;
            s_addr   <= 32'd0;
            s_wdata  <= 32'd0;
            sel      <= 4'd0;
            cnt      <= '0;
            err_irq  <= 1'b0;
            err_addr <= 32'd0;
        end else begin
            m_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_wstrb <= m_wstrb;
                        sel     <= dec_sel;
                        cnt     <= '0;
                        if (dec_hit) begin
                            s_valid <= NSLAVE'(1) << dec_sel;
                        end else begin
                            m_rdata <= ERR_DATA;
                            m_ready <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (rdy_sel) begin
                        m_rdata <= rdata_sel;
                        s_valid <= '0;
                        m_ready <= 1'b1;
                    end else if (timed_out) begin
                        m_rdata <= ERR_DATA;
                        s_valid <= '0;
                        m_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
            // A clear coinciding with a new error re-arms capture for that error.
            if (err_raise) begin
                err_irq <= 1'b1;
                if (!err_irq || err_clear) err_addr <= err_at;
            end else if (err_clear) begin
                err_irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iomem_router.sv
// tb/tb_iomem_router.sv - table-driven scoreboard bench for iomem_router
module tb_iomem_router;
    import iomem_pkg::*;

    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          m_valid = 1'b0;
    logic          m_ready;
    logic [3:0]    m_wstrb = 4'd0;
    logic [31:0]   m_addr = 32'd0;
    logic [31:0]   m_wdata = 32'd0;
    logic [31:0]   m_rdata;
    logic [NS-1:0] s_valid;
    logic [NS-1:0] s_ready;
    logic [3:0]    s_wstrb;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [32*NS-1:0] s_rdata;
    logic          err_irq;
    logic [31:0]   err_addr;
    logic          err_clear = 1'b0;

    iomem_router #(.NSLAVE(NS), .BASE(32'h0300_0000), .TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .s_valid(s_valid), .s_ready(s_ready),
        .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .err_irq(err_irq), .err_addr(err_addr), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    // Registered-ready slaves; slave 2 never answers on its own.
    logic [31:0]   mem [NS] = '{32'h0, 32'h0, 32'h2222_2222, 32'hC0DE_0003};
    logic [NS-1:0] auto_en = 4'b1011;
    logic [NS-1:0] auto_rdy = '0;
    logic [NS-1:0] force_rdy = '0;

    assign s_ready = auto_rdy | force_rdy;
    assign s_rdata = {mem[3], mem[2], mem[1], mem[0]};

    always @(posedge clk) begin
        for (int k = 0; k < NS; k++) begin
            if (!resetn) begin
                auto_rdy[k] <= 1'b0;
            end else if (auto_en[k] && s_valid[k] && !auto_rdy[k]) begin
                auto_rdy[k] <= 1'b1;
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) mem[k][8*b +: 8] <= s_wdata[8*b +: 8];
            end else begin
                auto_rdy[k] <= 1'b0;
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        chk;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        chk;
        logic [31:0] rdata;
        int          lat;
        logic [3:0]  sv;
        logic        irq;
        logic [31:0] eaddr;
    } vec_t;
    vec_t vecs[8];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cpu_access(input string nm, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic chk_rd, input logic [31:0] exp_rd,
                              input int fc, input logic [3:0] fmask, input logic clr,
                              output int lat, output int svcnt, output logic [3:0] sv1);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   done;
        e.rdata = exp_rd;
        e.chk   = chk_rd;
        exp_q.push_back(e);
        @(negedge clk);
        m_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb; err_clear = clr;
        cyc = 0; svcnt = 0; sv1 = 4'd0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            err_clear = 1'b0;
            if (cyc == fc + 1) force_rdy = 4'd0;
            if (cyc == fc) force_rdy = fmask;
            if (cyc == 1) sv1 = s_valid;
            if (s_valid != 4'd0) svcnt++;
            if (m_ready) begin
                done = 1'b1;
                m_valid = 1'b0;
                got = exp_q.pop_front();
                if (got.chk) chk({nm, "_rdata"}, m_rdata, got.rdata);
            end
        end
        lat = cyc;
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s_wait: got no m_ready expected m_ready within 40 cycles", nm);
            m_valid = 1'b0; force_rdy = 4'd0;
            void'(exp_q.pop_front());
        end else begin
            @(posedge clk); #1;
            chk({nm, "_pulse"}, 32'(m_ready), 32'd0);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk); err_clear = 1'b1;
        @(posedge clk); #1; err_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int lat, svcnt;
        logic [3:0] sv1;

        vecs[0] = '{32'h0300_0000, 32'h0000_0003, 4'hF, 1'b0, 32'h0,         3, 4'b0001, 1'b0, 32'h0};
        vecs[1] = '{32'h0300_0000, 32'h0,         4'h0, 1'b1, 32'h0000_0003, 3, 4'b0001, 1'b0, 32'h0};
        vecs[2] = '{32'h0301_0004, 32'h0000_AB00, 4'h2, 1'b0, 32'h0,         3, 4'b0010, 1'b0, 32'h0};
        vecs[3] = '{32'h0301_0000, 32'h0,         4'h0, 1'b1, 32'h0000_AB00, 3, 4'b0010, 1'b0, 32'h0};
        vecs[4] = '{32'h0303_0000, 32'h0,         4'h0, 1'b1, 32'hC0DE_0003, 3, 4'b1000, 1'b0, 32'h0};
        vecs[5] = '{32'h0304_0000, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1, 4'b0000, 1'b1, 32'h0304_0000};
        vecs[6] = '{32'h0400_0000, 32'h1234_5678, 4'hF, 1'b1, 32'hDEAD_BEEF, 1, 4'b0000, 1'b1, 32'h0304_0000};
        vecs[7] = '{32'h02FF_FFFC, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1, 4'b0000, 1'b1, 32'h0304_0000};

        repeat (3) @(posedge clk);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_m_rdata", m_rdata, 32'd0);
        chk("rst_err_irq", 32'(err_irq), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);

        for (int i = 0; i < 8; i++) begin
            cpu_access($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                       vecs[i].chk, vecs[i].rdata, 0, 4'd0, 1'b0, lat, svcnt, sv1);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_sv", i), 32'(sv1), 32'(vecs[i].sv));
            chk($sformatf("vec%0d_irq", i), 32'(err_irq), 32'(vecs[i].irq));
            chk($sformatf("vec%0d_eaddr", i), err_addr, vecs[i].eaddr);
        end
        pulse_clear();
        chk("clr_irq", 32'(err_irq), 32'd0);
        chk("clr_eaddr_kept", err_addr, 32'h0304_0000);

        cpu_access("tmo", 32'h0302_0010, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 0, 4'd0, 1'b0, lat, svcnt, sv1);
        chk("tmo_sv", 32'(sv1), 32'h4);
        chk("tmo_svcnt", 32'(svcnt), 32'd16);
        chk("tmo_lat", 32'(lat), 32'd17);
        chk("tmo_irq", 32'(err_irq), 32'd1);
        chk("tmo_eaddr", err_addr, 32'h0302_0010);
        pulse_clear();

        cpu_access("tmo_race", 32'h0302_0010, 32'h0, 4'h0, 1'b1, 32'h2222_2222, 16, 4'b0100, 1'b0, lat, svcnt, sv1);
        chk("tmo_race_svcnt", 32'(svcnt), 32'd16);
        chk("tmo_race_lat", 32'(lat), 32'd17);
        chk("tmo_race_irq", 32'(err_irq), 32'd0);

        cpu_access("nonsel", 32'h0303_0000, 32'h0, 4'h0, 1'b1, 32'hC0DE_0003, 1, 4'b0010, 1'b0, lat, svcnt, sv1);
        chk("nonsel_lat", 32'(lat), 32'd3);
        chk("nonsel_sv", 32'(sv1), 32'h8);

        cpu_access("race_pre", 32'h0304_0000, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 0, 4'd0, 1'b0, lat, svcnt, sv1);
        chk("race_pre_eaddr", err_addr, 32'h0304_0000);
        cpu_access("race", 32'h0305_0000, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 0, 4'd0, 1'b1, lat, svcnt, sv1);
        chk("race_irq", 32'(err_irq), 32'd1);
        chk("race_eaddr", err_addr, 32'h0305_0000);
        pulse_clear();
        chk("race_clr_irq", 32'(err_irq), 32'd0);

        cpu_access("rst_pre", 32'h0306_0000, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 0, 4'd0, 1'b0, lat, svcnt, sv1);
        @(negedge clk);
        m_valid = 1'b1; m_addr = 32'h0302_0000; m_wdata = 32'h5A5A_5A5A; m_wstrb = 4'hF;
        @(posedge clk); #1;
        chk("mid_sv", 32'(s_valid), 32'h4);
        chk("mid_wdata", s_wdata, 32'h5A5A_5A5A);
        repeat (2) @(posedge clk);
        @(negedge clk); resetn = 1'b0; m_valid = 1'b0;
        @(posedge clk); #1; resetn = 1'b1;
        chk("mrst_s_valid", 32'(s_valid), 32'd0);
        chk("mrst_m_ready", 32'(m_ready), 32'd0);
        chk("mrst_state", 32'(dut.state), 32'(ST_IDLE));
        chk("mrst_s_addr", s_addr, 32'd0);
        chk("mrst_s_wdata", s_wdata, 32'd0);
        chk("mrst_s_wstrb", 32'(s_wstrb), 32'd0);
        chk("mrst_m_rdata", m_rdata, 32'd0);
        chk("mrst_err_irq", 32'(err_irq), 32'd0);
        chk("mrst_err_addr", err_addr, 32'd0);
        @(posedge clk); #1;
        chk("mrst_idle_sv", 32'(s_valid), 32'd0);

        cpu_access("post_rst", 32'h0300_0000, 32'h0, 4'h0, 1'b1, 32'h0000_0003, 0, 4'd0, 1'b0, lat, svcnt, sv1);
        chk("post_rst_lat", 32'(lat), 32'd3);
        chk("post_rst_irq", 32'(err_irq), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iomem_router.md
# iomem_router

Single-master, multi-slave router for the PicoSoC `iomem` bus. It decodes each CPU `iomem` request into one of `NSLAVE` fixed 64 KiB windows starting at `BASE`, and forwards the request to that slave. It then returns the slave's response as a one-cycle `m_ready` pulse. A per-access timeout and unmapped-address handling guarantee the CPU never hangs, and a sticky error flag records the first faulting address. It sits in the board top between `fs_picosoc` and the memory-mapped peripherals (GPIO, CNN accelerator registers, timers).

## Interface
Parameters:
- `NSLAVE`, 4: number of slave windows (1..16).
- `BASE`, 32'h0300_0000: base of window 0; must be 64 KiB aligned. Window k = `BASE + k*32'h0001_0000`, 64 KiB each.
- `TIMEOUT`, 255: maximum number of cycles `s_valid` stays high before a forced error response (2..65535).
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on any error.

Ports:
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset, synchronous, active-low.
- `m_valid`, in, 1: CPU request valid.
- `m_ready`, out, 1: one-cycle response strobe.
- `m_wstrb`, in, 4: byte write strobes; 0 = read.
- `m_addr`, in, 32: request address.
- `m_wdata`, in, 32: write data.
- `m_rdata`, out, 32: read data, valid while `m_ready`=1.
- `s_valid`, out, NSLAVE: one-hot per-slave request.
- `s_ready`, in, NSLAVE: per-slave completion.
- `s_wstrb`, out, 4: latched strobes, shared by all slaves.
- `s_addr`, out, 32: latched address, shared.
- `s_wdata`, out, 32: latched write data, shared.
- `s_rdata`, in, 32*NSLAVE: slave k read data in bits [32k+31:32k].
- `err_irq`, out, 1: sticky error flag.
- `err_addr`, out, 32: address of the first error since the last clear.
- `err_clear`, in, 1: clears `err_irq` (single-cycle pulse).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - Transition occurs on `m_valid`=1 and `m_ready`=0.
  - Latch `m_addr`/`m_wdata`/`m_wstrb` into the `s_*` registers.
  - Decode: hit k when `m_addr[31:16] == BASE[31:16] + k` and k < NSLAVE.
  - On a hit: set `sel`=k, assert `s_valid[k]`, clear the timeout counter, and go to ACCESS.
  - On a miss: load `m_rdata`=ERR_DATA, raise an error, and go to RESP.
- **ACCESS**
  - Hold `s_valid[sel]` and increment the counter each cycle.
  - Only `s_ready[sel]` is sampled; all other `s_ready` bits are ignored.
  - If `s_ready[sel]`=1: capture `s_rdata[sel]` into `m_rdata`, drop `s_valid`, and go to RESP.
  - Else, if the counter equals TIMEOUT-1: drop `s_valid`, load `m_rdata`=ERR_DATA, raise an error, and go to RESP.
  - If `s_ready` and the timeout occur in the same cycle, `s_ready` wins and no error is raised.
- **RESP**: `m_ready`=1 for exactly one cycle, then go to IDLE.
- Writes to unmapped or timed-out targets are dropped, but the CPU still receives `m_ready`.
- **Error handling**
  - Raising an error sets `err_irq`.
  - `err_addr` is loaded only if `err_irq` was 0 beforehand, so it keeps the first error.
  - `err_clear` clears `err_irq`.
  - If `err_clear` and a new error occur in the same cycle, `err_irq` ends at 1 and `err_addr` is loaded with the new address.
- **Reset**, including mid-ACCESS:
  - FSM returns to IDLE.
  - `s_valid`=0 and `m_ready`=0.
  - `m_rdata`, `s_addr`, `s_wdata`, `s_wstrb`, and `err_addr` reset to 0; `err_irq`=0.
  - The pending slave access is abandoned without a response.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- **Mapped access**
  - `m_valid` is sampled at edge E0; `s_valid` is high after E0.
  - If `s_ready` is first high in the cycle after E(n), `m_ready` is high after E(n+1).
  - A registered slave asserts `s_ready` one cycle after `s_valid`, so `m_ready` is seen by the CPU at E3.
- **Unmapped access**: `m_ready` is high after E0; the CPU samples it at E1.
- **Timeout**: `s_valid` is high for exactly TIMEOUT cycles; `m_ready` is high in the following cycle.
- **Back-to-back accesses**: IDLE accepts a new `m_valid` in the cycle after RESP. The `m_ready`=0 guard rejects any stale request.
- Maximum occupancy per access is TIMEOUT+2 cycles.

## Structure
- Shared package `iomem_pkg` holds:
  - the state encoding (IDLE/ACCESS/RESP, 2 bits);
  - `IOMEM_WIN_BITS`=16;
  - the default `ERR_DATA`;
  - the default GPIO window base, 32'h0300_0000.
- One combinational sub-module, `iomem_addr_decode` (`addr` -> `hit`, `sel`), is reused by future multi-master variants.
- The counter width is `$clog2(TIMEOUT+1)`.

## Test plan
- **Register write/read:** 32'h0300_0000 write 32'h0000_0003 with `wstrb`=4'hF to slave 0 (registered-ready register model), then read it back.
  - Slave 0 sees the write; `m_ready` is seen by the CPU at E3 and pulses for one cycle.
  - The read returns 32'h3.
  - Other `s_valid` bits stay 0.
- **Unmapped read:** read 32'h0304_0000 with NSLAVE=4.
  - `m_ready` is high 1 cycle after acceptance, with `m_rdata`=32'hDEAD_BEEF.
  - `err_irq`=1 and `err_addr`=32'h0304_0000.
  - A second unmapped access to 32'h0400_0000 leaves `err_addr` unchanged.
- **Timeout:** TIMEOUT=16, slave 2 never ready, read 32'h0302_0010.
  - `s_valid[2]` is high for exactly 16 cycles, then `m_ready` is high with DEAD_BEEF and `err_irq`=1.
  - A `s_ready[2]` arriving on the 16th cycle gives a normal response with no error.
- **Non-selected ready:** slave 1 pulses `s_ready` while slave 3 is selected.
  - The pulse is ignored; the response comes only from slave 3's data.
- **Error clear race:** `err_clear` pulsed in the same cycle as a new error at 32'h0305_0000.
  - `err_irq` stays 1 and `err_addr`=32'h0305_0000.
  - A later `err_clear` alone drops `err_irq` to 0.
- **Reset mid-ACCESS:** `resetn`=0 for 1 cycle during ACCESS.
  - Next cycle: `s_valid`=0, `m_ready`=0, FSM in IDLE, all registers reset.
  - A fresh request afterwards completes normally.
